// File: rtl/piso_serializer_if.sv
// Word handshake between a parallel source and the serializer.
// Source drives data/valid, serializer returns ready.
interface piso_serializer_if #(
  parameter int MSB = 8
);
  logic [MSB-1:0] data;
  logic           valid;
  logic           ready;

  modport master (
    output data,
    output valid,
    input  ready
  );

  modport slave (
    input  data,
    input  valid,
    output ready
  );
endinterface

// File: rtl/piso_serializer.sv
// Parallel-in serial-out shifter, MSB- or LSB-first per frame.
// Back-to-back frames reload on the last bit with no idle gap.
module piso_serializer #(
  parameter int   MSB        = 8,
  parameter logic IDLE_LEVEL = 1'b0
) (
  input  logic               clk_i,
  input  logic               rstn_i,
  input  logic               en_i,
  input  logic               dir_i,
  piso_serializer_if.slave   s,
  output logic               data_o,
  output logic               busy_o,
  output logic               done_o
);

  localparam int CW = $clog2(MSB);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] SHIFT = 1'b1;

  logic [0:0]     state;
  logic [MSB-1:0] shreg;
  logic [CW-1:0]  cnt;
  logic           dir_q;
  logic           done_q;
  logic           last;
  logic           accept;

  assign last    = (state == SHIFT) && (cnt == '0);
  assign s.ready = (state == IDLE) || (last && en_i);
  assign accept  = s.valid && s.ready;

  assign busy_o = (state == SHIFT);
  assign done_o = done_q;

  // Serial bit comes straight off the active end of the shifter
  always_comb begin
    data_o = IDLE_LEVEL;
    if (state == SHIFT) begin
      data_o = dir_q ? shreg[0] : shreg[MSB-1];
    end
  end

  // Load, shift and frame-end sequencing
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state  <= IDLE;
      shreg  <= '0;
      cnt    <= '0;
      dir_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (accept) begin
        shreg <= s.data;
        dir_q <= dir_i;
        cnt   <= CW'(MSB - 1);
        state <= SHIFT;
        if (state == SHIFT) begin
          done_q <= 1'b1;
        end
      end else if (state == SHIFT && en_i) begin
        if (cnt != '0) begin
          cnt <= cnt - 1'b1;
          if (dir_q) begin
            shreg <= {1'b0, shreg[MSB-1:1]};
          end else begin
            shreg <= {shreg[MSB-2:0], 1'b0};
          end
        end else begin
          state  <= IDLE;
          done_q <= 1'b1;
        end
      end
    end
  end

endmodule
